// File: rtl/vae_pkg.sv
// Shared encodings for the latent-vector mu/var buffer sequencing blocks.
package vae_pkg;
  typedef enum logic [2:0] {
    ST_CLR, ST_IDLE, ST_MU, ST_VAR, ST_FLUSH, ST_DONE
  } state_e;

  localparam logic MODE_MU   = 1'b0;
  localparam logic MODE_VAR  = 1'b1;
  localparam int   DEPTH_DEF = 8;
endpackage

// File: rtl/seq_tag_reg.sv
// One-stage tag pipeline aligning valid/mode/first/last with the buffer's registered read data.
module seq_tag_reg (
  input  logic clk,
  input  logic rst,
  input  logic read_en_i,
  input  logic mode_i,
  input  logic first_i,
  input  logic last_i,
  output logic valid_o,
  output logic mode_o,
  output logic first_o,
  output logic last_o
);
  logic valid_q, mode_q, first_q, last_q;

  // Tags are gated by read_en so an idle cycle never carries stale first/last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= read_en_i;
      mode_q  <= read_en_i & mode_i;
      first_q <= read_en_i & first_i;
      last_q  <= read_en_i & last_i;
    end
  end

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign first_o = first_q;
  assign last_o  = last_q;
endmodule

// File: rtl/latent_buffer_sequencer.sv
// Sequences one mu/var circular weight buffer: per vector a mu pass then a var pass of DEPTH reads,
// tagging the buffer's registered output for the PE.
module latent_buffer_sequencer
  import vae_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             pe_ready,
  input  logic             abort,
  output logic             buf_rst,
  output logic             buf_read_en,
  output logic             buf_op_mode,
  output logic             pe_valid,
  output logic             pe_mode,
  output logic             pe_first,
  output logic             pe_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_idx
);
  localparam int COL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] nvec_q, nvec_d;
  logic             col_last;
  logic [CNT_W:0]   vec_nxt;

  assign col_last = (col_q == COL_W'(DEPTH - 1));
  assign vec_nxt  = {1'b0, vec_q} + (CNT_W + 1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLR;
      col_q   <= '0;
      vec_q   <= '0;
      nvec_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      vec_q   <= vec_d;
      nvec_q  <= nvec_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    vec_d       = vec_q;
    nvec_d      = nvec_q;
    buf_rst     = 1'b0;
    buf_read_en = 1'b0;
    buf_op_mode = MODE_MU;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_CLR: begin
        // Forces the buffer pointer back to 0 whatever it held before reset or abort.
        buf_rst = 1'b1;
        col_d   = '0;
        vec_d   = '0;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (start) begin
          if (num_vec != '0) begin
            nvec_d  = num_vec;
            col_d   = '0;
            vec_d   = '0;
            state_d = ST_MU;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_MU, ST_VAR: begin
        busy        = 1'b1;
        buf_op_mode = (state_q == ST_VAR) ? MODE_VAR : MODE_MU;
        if (abort) begin
          state_d = ST_CLR;
        end else begin
          buf_read_en = pe_ready;
          if (pe_ready) begin
            if (col_last) begin
              col_d = '0;
              if (state_q == ST_MU) begin
                state_d = ST_VAR;
              end else begin
                vec_d   = vec_nxt[CNT_W-1:0];
                state_d = (vec_nxt != {1'b0, nvec_q}) ? ST_MU : ST_FLUSH;
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end
      ST_FLUSH: begin
        // Lets the last var word's tags reach the PE before done.
        busy    = 1'b1;
        state_d = abort ? ST_CLR : ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_CLR;
    endcase
  end

  assign vec_idx = vec_q;

  seq_tag_reg u_tag (
    .clk       (clk),
    .rst       (rst),
    .read_en_i (buf_read_en),
    .mode_i    (buf_op_mode),
    .first_i   (col_q == '0),
    .last_i    (col_last),
    .valid_o   (pe_valid),
    .mode_o    (pe_mode),
    .first_o   (pe_first),
    .last_o    (pe_last)
  );
endmodule
